// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the pc_sequencer block and the program counter it steers.
package pc_seq_pkg;

  localparam int DEFAULT_ADDR_W    = 24;
  localparam int DEFAULT_RAS_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  // pc_control encodings, decoded identically by the program counter
  localparam logic [1:0] PC_HOLD   = 2'b00;
  localparam logic [1:0] PC_INC    = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Circular return-address stack; a push when full silently overwrites the oldest entry.
module return_stack #(
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] data,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] MAX_COUNT = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   count;

  assign empty = (count == '0);
  assign full  = (count == MAX_COUNT);
  assign data  = mem[ptr - PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr] <= push_data;
    end
  end

  // count saturates at DEPTH so that wrapped-over entries are never popped twice
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) begin
        count <= count + (PTR_W + 1)'(1);
      end
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - (PTR_W + 1)'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving the program counter; define PC_SEQUENCER_RAS_EN
// to add a call/return stack (otherwise call acts as jump and ret is ignored).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int RAS_DEPTH = DEFAULT_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              imem_ready,
  input  logic              exec_done,
  input  logic              jump_valid,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              call_valid,
  input  logic              ret_valid,
  output logic [1:0]        pc_control,
  output logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              imem_req,
  output logic [31:0]       retired,
  output logic              ras_error
);

  state_t state, next_state;
  logic   retire;

  // halt outranks exec_done, so a halting instruction never retires
  assign retire = (state == EXEC) && !halt && exec_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (start) next_state = FETCH;
      FETCH: if (imem_ready) next_state = EXEC;
      EXEC: begin
        if (halt) next_state = HALT;
        else if (exec_done) next_state = FETCH;
      end
      HALT:  next_state = HALT;
    endcase
  end

`ifdef PC_SEQUENCER_RAS_EN
  logic              ras_push, ras_pop, ras_empty, ras_full;
  logic [ADDR_W-1:0] ras_data;
  logic              unused_ras;

  assign ras_pop    = retire && ret_valid;
  assign ras_push   = retire && !ret_valid && call_valid;
  assign unused_ras = ras_full;

  return_stack #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_in + ADDR_W'(1)),
    .data      (ras_data),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ras_error <= 1'b0;
    end else if (ras_pop && ras_empty) begin
      ras_error <= 1'b1;
    end
  end
`else
  logic unused_ras;

  assign unused_ras = ^{pc_in, ret_valid, RAS_DEPTH[0]};
  assign ras_error  = 1'b0;
`endif

  assign imem_req    = (state == FETCH);
  assign branch_addr = branch_target;

  always_comb begin
    pc_control = PC_HOLD;
    jump_addr  = jump_target;
    if (retire) begin
`ifdef PC_SEQUENCER_RAS_EN
      if (ret_valid) begin
        pc_control = PC_JUMP;
        jump_addr  = ras_empty ? '0 : ras_data;
      end else
`endif
      if (call_valid || jump_valid) begin
        pc_control = PC_JUMP;
      end else if (branch_taken) begin
        pc_control = PC_BRANCH;
      end else begin
        pc_control = PC_INC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + 32'd1;
    end
  end

endmodule
